// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the command master.
// Holds the response codes, the FSM state encoding and the default bus widths.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 4;
    localparam int AXI_DATA_W = 32;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    // States in which the master is waiting on the slave.
    function automatic logic is_bus_wait(state_t s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_RESP);
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master_watchdog.sv
// Handshake watchdog: counts wait cycles and raises a sticky flag at the limit.
// The counter stops once the flag is set, so it never wraps.
module axi_lite_cmd_master_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk_axi,
    input  logic axi_reset,
    input  logic clear,
    input  logic busy,
    output logic err_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_axi) begin
        if (axi_reset) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else if (clear) begin
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else if (busy && !err_timeout) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT_CYC - 1))
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator that turns single-beat commands into AW/W/B or AR/R transactions.
// One response is returned per command; every output is registered.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W      = AXI_ADDR_W,
    parameter int DATA_W      = AXI_DATA_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk_axi,
    input  logic                axi_reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                err_timeout,

    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    state_t state;
    logic   accept;
    logic   aw_fin;
    logic   w_fin;

    assign accept = (state == IDLE) && cmd_ready && cmd_valid;
    // A channel counts as finished if it already handshook or handshakes this cycle.
    assign aw_fin = !awvalid || awready;
    assign w_fin  = !wvalid  || wready;

    always_ff @(posedge clk_axi) begin
        if (axi_reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= RESP_OKAY;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        rsp_write <= cmd_write;
                        if (cmd_addr[1:0] != 2'b00) begin
                            rsp_resp  <= RESP_SLVERR;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RSP;
                        end else if (cmd_write) begin
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                            wstrb   <= cmd_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            araddr  <= cmd_addr;
                            arvalid <= 1'b1;
                            state   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    axi_lite_cmd_master_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_axi     (clk_axi),
        .axi_reset   (axi_reset),
        .clear       (accept),
        .busy        (is_bus_wait(state)),
        .err_timeout (err_timeout)
    );

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: the slave side is driven by hand step by step.
// Outputs are sampled 1ns after each rising edge.
module tb_axi_lite_cmd_master;

    logic        clk_axi = 1'b0;
    logic        axi_reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        err_timeout;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0, rready;

    int checks = 0;
    int errors = 0;

    axi_lite_cmd_master dut (
        .clk_axi(clk_axi), .axi_reset(axi_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_timeout(err_timeout),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic tick();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_data", awaddr | araddr | wdata | rsp_rdata, 32'd0);
        axi_reset = 1'b0;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write, zero-wait slave
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0;
        cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        chk("w1_aw_w_valid", {awvalid, wvalid, cmd_ready, bready}, 32'b1100);
        chk("w1_wdata", wdata, 32'hDEADBEEF);
        chk("w1_awaddr_wstrb", {awaddr, wstrb}, 32'h0F);
        tick();
        chk("w1_after_hs", {awvalid, wvalid, bready, cmd_ready}, 32'b0010);
        tick();
        chk("w1_rsp", {rsp_valid, rsp_write, bready}, 32'b110);
        chk("w1_resp_rdata", {rsp_resp, rsp_rdata[29:0]}, 32'd0);
        bvalid = 1'b0;
        tick();
        chk("w1_next_ready_5cyc", {cmd_ready, rsp_valid}, 32'b10);

        // Write, awready delayed 3 cycles, wready immediate
        awready = 1'b0; wready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h12345678;
        tick();
        cmd_valid = 1'b0;
        chk("w2_c1", {awvalid, wvalid}, 32'b11);
        tick();
        chk("w2_c2", {awvalid, wvalid, bready}, 32'b100);
        chk("w2_awaddr_c2", 32'(awaddr), 32'h8);
        tick();
        chk("w2_c3", {awvalid, bready, 28'(awaddr)}, {2'b10, 28'h8});
        tick();
        chk("w2_c4", {awvalid, bready, 28'(awaddr)}, {2'b10, 28'h8});
        awready = 1'b1;
        tick();
        chk("w2_aw_done", {awvalid, wvalid, bready}, 32'b001);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("w2_rsp", {rsp_valid, rsp_write, 2'b00, rsp_resp}, 32'b110000);
        tick();
        chk("w2_single_rsp", {rsp_valid, cmd_ready}, 32'b01);

        // Read addr 0x4, rvalid 2 cycles late, rsp_ready held low 4 cycles
        rsp_ready = 1'b0; arready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
        tick();
        cmd_valid = 1'b0;
        chk("r_arvalid", {arvalid, awvalid, wvalid, 28'(araddr)}, {3'b100, 28'h4});
        tick();
        chk("r_arvalid_held", 32'(arvalid), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r_ar_done", {arvalid, rready}, 32'b01);
        tick();
        chk("r_wait1", {rready, rsp_valid}, 32'b10);
        rvalid = 1'b1; rdata = 32'h00000003; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'hFFFFFFFF;
        chk("r_rsp", {rsp_valid, rsp_write, rready, rsp_resp}, 32'b10000);
        chk("r_rdata", rsp_rdata, 32'h3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_hold_valid", {rsp_valid, rsp_write, cmd_ready}, 32'b100);
            chk("r_hold_rdata", rsp_rdata, 32'h3);
        end
        rsp_ready = 1'b1;
        tick();
        chk("r_done", {rsp_valid, cmd_ready}, 32'b01);

        // Misaligned address: straight to SLVERR, no bus traffic
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2;
        tick();
        cmd_valid = 1'b0;
        chk("mis_no_bus", {awvalid, wvalid, arvalid}, 32'd0);
        chk("mis_rsp", {rsp_valid, rsp_resp}, 32'b110);
        tick();
        chk("mis_done", {rsp_valid, cmd_ready, awvalid, arvalid}, 32'b0100);

        // Timeout: bvalid withheld for more than 256 wait cycles
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'hCAFEF00D;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i < 256; i++) tick();
        chk("to_before", {err_timeout, bready}, 32'b01);
        tick();
        chk("to_at_256", {err_timeout, bready}, 32'b11);
        tick(); tick(); tick();
        chk("to_sticky", {err_timeout, bready, rsp_valid}, 32'b110);
        bvalid = 1'b1; bresp = 2'b01;
        tick();
        bvalid = 1'b0;
        chk("to_late_b", {rsp_valid, rsp_resp, err_timeout}, 32'b1011);
        tick();
        chk("to_idle_err", {cmd_ready, err_timeout}, 32'b11);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000A5A5; rresp = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
        tick();
        cmd_valid = 1'b0;
        chk("to_cleared", 32'(err_timeout), 32'd0);
        tick(); tick();
        chk("r2_rdata", rsp_rdata, 32'h0000A5A5);
        arready = 1'b0; rvalid = 1'b0;
        tick();
        chk("r2_done", {rsp_valid, cmd_ready}, 32'b01);

        // Reset while awvalid is high
        awready = 1'b0; wready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h55AA55AA;
        tick();
        cmd_valid = 1'b0;
        chk("mr_awvalid", {awvalid, wvalid}, 32'b11);
        axi_reset = 1'b1;
        tick();
        chk("mr_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 32'd0);
        chk("mr_data", {28'(awaddr), 4'(wdata)}, 32'd0);
        axi_reset = 1'b0;
        tick();
        chk("mr_ready", {cmd_ready, awvalid}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
